// File: rtl/pinch_pkg.sv
// rtl/pinch_pkg.sv - shared INM encodings and detector state enum
package pinch_pkg;

   localparam logic [1:0] INM_OFF   = 2'b00;
   localparam logic [1:0] INM_UP    = 2'b01;
   localparam logic [1:0] INM_DOWN  = 2'b10;
   localparam logic [1:0] INM_BRAKE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_MON,
      S_TRIP
   } state_t;

   function automatic logic inm_moving(input logic [1:0] inm);
      return (inm == INM_UP) || (inm == INM_DOWN);
   endfunction

endpackage

// File: rtl/pinch_run_counter.sv
// rtl/pinch_run_counter.sv - saturating consecutive-event run counter
module pinch_run_counter #(
   parameter int TARGET = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic hit,
   output logic done
);

   localparam int W = $clog2(TARGET + 1);
   localparam logic [W-1:0] L_TGT = W'(TARGET);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_next;

   if (TARGET < 1) begin : g_tgt_chk
      $error("pinch_run_counter: TARGET must be at least 1");
   end

   always_comb begin
      w_cnt_next = r_cnt;
      if (clr) begin
         w_cnt_next = '0;
      end else if (en) begin
         if (!hit) begin
            w_cnt_next = '0;
         end else if (r_cnt != L_TGT) begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   // done reflects the run including the event sampled on this edge
   assign done = !clr && (w_cnt_next == L_TGT);

endmodule

// File: rtl/pinch_sensor_detect.sv
// rtl/pinch_sensor_detect.sv - pinch detection with hysteresis, persistence, inrush blanking and saturation fault
module pinch_sensor_detect
   import pinch_pkg::*;
#(
   parameter int ADC_W     = 10,
   parameter int THR_ON    = 600,
   parameter int THR_OFF   = 400,
   parameter int N_ON      = 3,
   parameter int N_OFF     = 8,
   parameter int BLANK_CYC = 50,
   parameter int HOLD_CYC  = 200,
   parameter int SAT_N     = 16
) (
   input  logic             SYSCLK,
   input  logic             RST_N,
   input  logic [1:0]       INM,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic             stop_signal,
   output logic             sensor_fault,
   output logic [7:0]       trip_count
);

   localparam int BW = $clog2(BLANK_CYC) + 1;
   localparam int HW = $clog2(HOLD_CYC) + 1;
   localparam logic [BW-1:0]    L_BLANK_LAST = BW'(BLANK_CYC - 1);
   localparam logic [HW-1:0]    L_HOLD_LAST  = HW'(HOLD_CYC - 1);
   localparam logic [ADC_W-1:0] L_THR_ON     = ADC_W'(THR_ON);
   localparam logic [ADC_W-1:0] L_THR_OFF    = ADC_W'(THR_OFF);

   if (THR_OFF >= THR_ON) begin : g_thr_chk
      $error("pinch_sensor_detect: THR_OFF must be below THR_ON");
   end
   if (N_ON < 1 || N_OFF < 1 || BLANK_CYC < 1 || HOLD_CYC < 1 || SAT_N < 1) begin : g_cnt_chk
      $error("pinch_sensor_detect: count parameters must be nonzero");
   end

   state_t          r_state;
   state_t          w_state_next;
   logic [1:0]      r_dir;
   logic [1:0]      w_dir_next;
   logic [BW-1:0]   r_blank_cnt;
   logic [HW-1:0]   r_hold_cnt;
   logic            r_stop;
   logic            r_fault;
   logic [7:0]      r_trip_cnt;
   logic            w_blank_rst;
   logic            w_trip;
   logic            w_moving;
   logic            w_dir_chg;
   logic            w_on_done;
   logic            w_off_done;
   logic            w_sat_done;
   logic            w_hold_done;

   assign w_moving    = inm_moving(INM);
   assign w_dir_chg   = w_moving && (INM != r_dir);
   assign w_hold_done = (r_hold_cnt == L_HOLD_LAST);

   pinch_run_counter #(.TARGET(N_ON)) u_on_run (
      .clk   (SYSCLK),
      .rst_n (RST_N),
      .clr   (r_state != S_MON),
      .en    (adc_valid),
      .hit   (adc_data >= L_THR_ON),
      .done  (w_on_done)
   );

   pinch_run_counter #(.TARGET(N_OFF)) u_off_run (
      .clk   (SYSCLK),
      .rst_n (RST_N),
      .clr   (r_state != S_TRIP),
      .en    (adc_valid),
      .hit   (adc_data < L_THR_OFF),
      .done  (w_off_done)
   );

   pinch_run_counter #(.TARGET(SAT_N)) u_sat_run (
      .clk   (SYSCLK),
      .rst_n (RST_N),
      .clr   (1'b0),
      .en    (adc_valid),
      .hit   (adc_data == {ADC_W{1'b1}}),
      .done  (w_sat_done)
   );

   always_ff @(posedge SYSCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_dir   <= INM_OFF;
      end else begin
         r_state <= w_state_next;
         r_dir   <= w_dir_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dir_next   = r_dir;
      w_blank_rst  = 1'b0;
      w_trip       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_moving) begin
               w_state_next = S_BLANK;
               w_dir_next   = INM;
               w_blank_rst  = 1'b1;
            end
         end
         S_BLANK: begin
            if (!w_moving) begin
               w_state_next = S_IDLE;
            end else if (w_dir_chg) begin
               w_dir_next  = INM;
               w_blank_rst = 1'b1;
            end else if (r_blank_cnt == L_BLANK_LAST) begin
               w_state_next = S_MON;
            end
         end
         S_MON: begin
            // a completed trip run outranks any INM change on the same edge
            if (w_on_done) begin
               w_state_next = S_TRIP;
               w_trip       = 1'b1;
            end else if (!w_moving) begin
               w_state_next = S_IDLE;
            end else if (w_dir_chg) begin
               w_state_next = S_BLANK;
               w_dir_next   = INM;
               w_blank_rst  = 1'b1;
            end
         end
         S_TRIP: begin
            if (w_hold_done && w_off_done) begin
               if (w_moving) begin
                  w_state_next = S_BLANK;
                  w_dir_next   = INM;
                  w_blank_rst  = 1'b1;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge SYSCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_blank_cnt <= '0;
         r_hold_cnt  <= '0;
      end else begin
         if (r_state != S_BLANK || w_blank_rst) begin
            r_blank_cnt <= '0;
         end else if (r_blank_cnt != L_BLANK_LAST) begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
         end
         if (r_state != S_TRIP) begin
            r_hold_cnt <= '0;
         end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge SYSCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_stop     <= 1'b0;
         r_fault    <= 1'b0;
         r_trip_cnt <= 8'd0;
      end else begin
         r_fault <= r_fault | w_sat_done;
         r_stop  <= (w_state_next == S_TRIP) | r_fault | w_sat_done;
         if (w_trip && r_trip_cnt != 8'hFF) begin
            r_trip_cnt <= r_trip_cnt + 8'd1;
         end
      end
   end

   assign stop_signal  = r_stop;
   assign sensor_fault = r_fault;
   assign trip_count   = r_trip_cnt;

endmodule

// File: tb/tb_pinch_sensor_detect.sv
// tb/tb_pinch_sensor_detect.sv - randomized and directed bench against a behavioural pinch-detector model
module tb_pinch_sensor_detect;

   localparam int THR_ON = 600, THR_OFF = 400, N_ON = 3, N_OFF = 8;
   localparam int BLANK_CYC = 50, HOLD_CYC = 200, SAT_N = 16;
   localparam int MD_IDLE = 0, MD_BLANK = 1, MD_MON = 2, MD_TRIP = 3;

   logic       SYSCLK = 1'b0;
   logic       RST_N;
   logic [1:0] INM;
   logic       adc_valid;
   logic [9:0] adc_data;
   logic       stop_signal;
   logic       sensor_fault;
   logic [7:0] trip_count;

   int vectors = 0;
   int miscompares = 0;

   int m_mode, m_blank_left, m_dir, m_on_run, m_off_run, m_age, m_sat_run;
   int m_fault, m_trips, m_stop;

   pinch_sensor_detect dut (
      .SYSCLK       (SYSCLK),
      .RST_N        (RST_N),
      .INM          (INM),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .stop_signal  (stop_signal),
      .sensor_fault (sensor_fault),
      .trip_count   (trip_count)
   );

   always #5 SYSCLK = ~SYSCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Behavioural model: modes with a blanking countdown, trip age and run lengths
   always @(posedge SYSCLK or negedge RST_N) begin
      if (!RST_N) begin
         m_mode = MD_IDLE; m_blank_left = 0; m_dir = 0; m_on_run = 0;
         m_off_run = 0; m_age = 0; m_sat_run = 0; m_fault = 0; m_trips = 0; m_stop = 0;
      end else begin
         bit moving;
         if (adc_valid) m_sat_run = (adc_data == 10'h3FF) ? m_sat_run + 1 : 0;
         if (m_sat_run >= SAT_N) m_fault = 1;
         moving = (INM == 2'b01) || (INM == 2'b10);
         case (m_mode)
            MD_IDLE: if (moving) begin
               m_mode = MD_BLANK; m_blank_left = BLANK_CYC; m_dir = int'(INM);
            end
            MD_BLANK: begin
               if (!moving) m_mode = MD_IDLE;
               else if (int'(INM) != m_dir) begin
                  m_blank_left = BLANK_CYC; m_dir = int'(INM);
               end else begin
                  m_blank_left--;
                  if (m_blank_left == 0) begin m_mode = MD_MON; m_on_run = 0; end
               end
            end
            MD_MON: begin
               if (adc_valid) m_on_run = (adc_data >= THR_ON) ? m_on_run + 1 : 0;
               if (m_on_run >= N_ON) begin
                  m_mode = MD_TRIP; m_age = 0; m_off_run = 0;
                  if (m_trips < 255) m_trips++;
               end else if (!moving) m_mode = MD_IDLE;
               else if (int'(INM) != m_dir) begin
                  m_mode = MD_BLANK; m_blank_left = BLANK_CYC; m_dir = int'(INM);
               end
            end
            default: begin
               m_age++;
               if (adc_valid) m_off_run = (adc_data < THR_OFF) ? m_off_run + 1 : 0;
               if (m_age >= HOLD_CYC && m_off_run >= N_OFF) begin
                  if (moving) begin
                     m_mode = MD_BLANK; m_blank_left = BLANK_CYC; m_dir = int'(INM);
                  end else m_mode = MD_IDLE;
               end
            end
         endcase
         m_stop = (m_mode == MD_TRIP) || (m_fault != 0);
      end
   end

   always @(negedge SYSCLK) begin
      vectors++;
      if (int'(stop_signal) != m_stop || $isunknown(stop_signal)) begin
         miscompares++;
         $display("FAIL model_stop t=%0t: got %0d, required %0d", $time, stop_signal, m_stop);
      end
      if (int'(sensor_fault) != m_fault || $isunknown(sensor_fault)) begin
         miscompares++;
         $display("FAIL model_fault t=%0t: got %0d, required %0d", $time, sensor_fault, m_fault);
      end
      if (int'(trip_count) != m_trips || $isunknown(trip_count)) begin
         miscompares++;
         $display("FAIL model_trips t=%0t: got %0d, required %0d", $time, trip_count, m_trips);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic [1:0] inm, input logic v, input logic [9:0] d);
      INM = inm; adc_valid = v; adc_data = d;
      @(posedge SYSCLK);
      #1;
   endtask

   task automatic wait_stop(input logic lvl, input logic [1:0] inm, input logic [9:0] d,
                            input int bound, output int n);
      n = 0;
      while (stop_signal !== lvl && n < bound) begin
         tick(inm, 1'b1, d);
         n++;
      end
   endtask

   initial begin
      int n;
      int inm_cur;
      RST_N = 1'b0; INM = 2'b00; adc_valid = 1'b0; adc_data = '0;
      repeat (3) @(posedge SYSCLK);
      #1;
      check("reset_stop", int'(stop_signal), 0);
      check("reset_fault", int'(sensor_fault), 0);
      check("reset_trips", int'(trip_count), 0);
      RST_N = 1'b1;

      // first trip after blanking
      wait_stop(1'b1, 2'b01, 10'd700, 200, n);
      check("first_trip_edge", n, 54);
      check("first_trip_count", int'(trip_count), 1);

      // release exactly HOLD_CYC after rise
      wait_stop(1'b0, 2'b01, 10'd300, 400, n);
      check("hold_release", n, 200);

      // interrupted high run does not trip
      repeat (50) tick(2'b01, 1'b1, 10'd100);
      tick(2'b01, 1'b1, 10'd700); check("run_a", int'(stop_signal), 0);
      tick(2'b01, 1'b1, 10'd700); check("run_b", int'(stop_signal), 0);
      tick(2'b01, 1'b1, 10'd500); check("run_c", int'(stop_signal), 0);
      tick(2'b01, 1'b1, 10'd700); check("run_d", int'(stop_signal), 0);
      tick(2'b01, 1'b1, 10'd700); check("run_e", int'(stop_signal), 0);
      tick(2'b01, 1'b1, 10'd700); check("run_trip", int'(stop_signal), 1);

      // a late 450 defers release until a fresh low run completes
      n = 0;
      while (stop_signal === 1'b1 && n < 400) begin
         n++;
         tick(2'b01, 1'b1, (n == 195) ? 10'd450 : 10'd300);
      end
      check("deferred_release", n, 203);

      // trip wins over INM going off on the same edge
      repeat (50) tick(2'b01, 1'b1, 10'd100);
      tick(2'b01, 1'b1, 10'd700);
      tick(2'b01, 1'b1, 10'd700);
      tick(2'b00, 1'b1, 10'd700);
      check("trip_vs_off", int'(stop_signal), 1);
      check("trip_vs_off_count", int'(trip_count), 3);
      wait_stop(1'b0, 2'b00, 10'd300, 400, n);
      check("release_to_idle", n, 200);

      // direction change in monitoring restarts blanking
      tick(2'b01, 1'b1, 10'd100);
      repeat (50) tick(2'b01, 1'b1, 10'd100);
      tick(2'b01, 1'b1, 10'd100);
      tick(2'b10, 1'b1, 10'd700);
      repeat (52) tick(2'b10, 1'b1, 10'd700);
      check("reblank_ignored", int'(stop_signal), 0);
      tick(2'b10, 1'b1, 10'd700);
      check("reblank_trip", int'(stop_signal), 1);
      check("reblank_count", int'(trip_count), 4);
      wait_stop(1'b0, 2'b00, 10'd300, 400, n);

      // randomized segments against the model
      inm_cur = 1;
      for (int s = 0; s < 80; s++) begin
         int len, cls;
         if ($urandom_range(0, 9) < 2) inm_cur = int'($urandom_range(0, 3));
         len = int'($urandom_range(1, 40));
         cls = int'($urandom_range(0, 2));
         for (int k = 0; k < len; k++) begin
            logic [9:0] d;
            case (cls)
               0: d = 10'($urandom_range(0, 399));
               1: d = 10'($urandom_range(400, 599));
               default: d = 10'($urandom_range(600, 1022));
            endcase
            tick(2'(inm_cur), ($urandom_range(0, 9) < 8), d);
         end
      end
      wait_stop(1'b0, 2'b00, 10'd100, 600, n);
      check("random_flush", int'(stop_signal), 0);

      // saturation fault
      repeat (15) tick(2'b00, 1'b1, 10'h3FF);
      check("fault_not_yet", int'(sensor_fault), 0);
      tick(2'b00, 1'b1, 10'h3FF);
      check("fault_set", int'(sensor_fault), 1);
      check("fault_stop", int'(stop_signal), 1);
      repeat (30) tick(2'b00, 1'b1, 10'd100);
      check("fault_sticky", int'(sensor_fault), 1);
      check("fault_stop_sticky", int'(stop_signal), 1);

      // asynchronous reset in the middle of a trip
      repeat (54) tick(2'b01, 1'b1, 10'd700);
      #3;
      RST_N = 1'b0;
      #1;
      check("async_rst_stop", int'(stop_signal), 0);
      check("async_rst_fault", int'(sensor_fault), 0);
      check("async_rst_trips", int'(trip_count), 0);
      tick(2'b00, 1'b0, 10'd0);
      tick(2'b00, 1'b0, 10'd0);
      RST_N = 1'b1;
      wait_stop(1'b1, 2'b01, 10'd700, 200, n);
      check("restart_trip_edge", n, 54);
      check("restart_trip_count", int'(trip_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
